// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the single-bus CPU control sequencer.
// Contents: opcode values (IR[31:27]), control-step state encoding,
// ALU operation codes and small decode helpers used by the sequencer.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU operation codes driven on 'operation'.
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;

    typedef enum logic [3:0] {
        S_RST = 4'd0,
        T0    = 4'd1,
        T1    = 4'd2,
        T2    = 4'd3,
        T3    = 4'd4,
        T4    = 4'd5,
        T5    = 4'd6,
        T6    = 4'd7,
        T7    = 4'd8,
        HALT  = 4'd9
    } ctrl_state_t;

    // Three-register ALU instructions: Y <- Rb, Z <- Y op Rc, Ra <- Z.
    function automatic logic is_rtype(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_SHL);
    endfunction

    // Register-plus-constant instructions that write Z back into Ra.
    function automatic logic is_imm(input logic [4:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_LDI);
    endfunction

    // Steps that talk to memory and therefore stretch by the wait count.
    function automatic logic is_mem_step(input ctrl_state_t s, input logic [4:0] op);
        return (s == T1) || ((s == T6) && (op == OP_LD)) || ((s == T7) && (op == OP_ST));
    endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// Loadable 4-bit down-counter used to stretch memory steps.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high clear
//   load       in   load load_value (has priority over dec)
//   load_value in 4 value loaded on entry to a memory step
//   dec        in   decrement by one (ignored at zero)
//   zero       out  count is zero, the memory step may advance
module ctrl_wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/mini_src_control_unit.sv
// Hardwired control-step sequencer for the single-bus CPU datapath.
// Fetches (T0-T2), decodes IR[31:27] in T3 and walks the instruction's
// control steps, one step per clock. All strobes are decoded from the
// registered step, so they are stable for the whole step.
// Ports:
//   Clock, Reset          clock and synchronous active-high reset
//   IR[31:0]              instruction register contents
//   CON_out               branch condition flip-flop
//   Stop                  halt once the current instruction finishes
//   PCout..operation      datapath strobes and ALU op code
//   Run                   executing (not in reset step, not halted)
//   Illegal               one-cycle pulse on an undefined opcode
//   dbg_state             current control step encoding
module mini_src_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        CON_out,
    input  logic        Stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        ZHighout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        InPortout,
    output logic        OutPortin,
    output logic        CONin,
    output logic        BAout,
    output logic        GRA,
    output logic        GRB,
    output logic        GRC,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  operation,
    output logic        Run,
    output logic        Illegal,
    output logic [3:0]  dbg_state
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    ctrl_state_t state, next_state;
    logic        stop_seen;
    logic        stop_pending;
    logic        last_step;
    logic        wait_zero;
    logic        wait_load;
    logic        wait_dec;
    logic [4:0]  opcode;
    logic [4:0]  imm_op;
    logic        unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign dbg_state = state;
    assign Run       = (state != S_RST) && (state != HALT);

    // A Stop seen at any time during the instruction, including its final
    // step, diverts the final step into HALT.
    assign stop_pending = stop_seen | Stop;

    // Constant-add instructions use ADD except the two logical immediates.
    assign imm_op = (opcode == OP_ANDI) ? ALU_AND :
                    (opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;

    // The counter is loaded only when a memory step is first entered, so a
    // step held in place keeps counting down instead of reloading.
    assign wait_load = (next_state != state) && is_mem_step(next_state, opcode);
    assign wait_dec  = is_mem_step(state, opcode) && !wait_zero;

    ctrl_wait_counter u_wait (
        .clk        (Clock),
        .reset      (Reset),
        .load       (wait_load),
        .load_value (WAIT_INIT),
        .dec        (wait_dec),
        .zero       (wait_zero)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_RST;
            stop_seen <= 1'b0;
        end else begin
            state <= next_state;
            if ((next_state == T0) || (next_state == HALT)) begin
                stop_seen <= 1'b0;
            end else if (Run && Stop) begin
                stop_seen <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        last_step  = 1'b0;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; Write = 1'b0;
        IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; ZHighout = 1'b0;
        HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
        Cout = 1'b0; InPortout = 1'b0; OutPortin = 1'b0; CONin = 1'b0; BAout = 1'b0;
        GRA = 1'b0; GRB = 1'b0; GRC = 1'b0; Rin = 1'b0; Rout = 1'b0;
        operation = ALU_NONE;
        Illegal   = 1'b0;

        unique case (state)
            S_RST: next_state = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1;
                next_state = T1;
            end
            T1: begin
                Read = 1'b1; MDRin = 1'b1;
                if (wait_zero) next_state = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                next_state = T3;
            end
            T3: begin
                next_state = T4;
                if (is_rtype(opcode)) begin
                    GRB = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_imm(opcode) || (opcode == OP_LD) || (opcode == OP_ST)) begin
                    // Base register reads as zero through BAout for R0-relative forms.
                    GRB = 1'b1; Yin = 1'b1;
                    if ((opcode == OP_LDI) || (opcode == OP_LD) || (opcode == OP_ST)) BAout = 1'b1;
                    else Rout = 1'b1;
                end else begin
                    case (opcode)
                        OP_NEG, OP_NOT: begin
                            GRB = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode;
                        end
                        OP_MUL, OP_DIV: begin
                            GRA = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        end
                        OP_BR: begin
                            GRA = 1'b1; Rout = 1'b1; CONin = 1'b1;
                        end
                        OP_MFHI: begin
                            HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; last_step = 1'b1;
                        end
                        OP_MFLO: begin
                            LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; last_step = 1'b1;
                        end
                        OP_IN: begin
                            InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1; last_step = 1'b1;
                        end
                        OP_OUT: begin
                            GRA = 1'b1; Rout = 1'b1; OutPortin = 1'b1; last_step = 1'b1;
                        end
                        OP_JR: begin
                            GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; last_step = 1'b1;
                        end
                        OP_NOP:  last_step = 1'b1;
                        OP_HALT: next_state = HALT;
                        default: begin
                            Illegal = 1'b1; last_step = 1'b1;
                        end
                    endcase
                end
            end
            T4: begin
                if (is_rtype(opcode)) begin
                    GRC = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode;
                    next_state = T5;
                end else if (is_imm(opcode) || (opcode == OP_LD) || (opcode == OP_ST)) begin
                    Cout = 1'b1; Zin = 1'b1; operation = imm_op;
                    next_state = T5;
                end else if ((opcode == OP_NEG) || (opcode == OP_NOT)) begin
                    Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; last_step = 1'b1;
                end else if ((opcode == OP_MUL) || (opcode == OP_DIV)) begin
                    GRB = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode;
                    next_state = T5;
                end else if (opcode == OP_BR) begin
                    PCout = 1'b1; Yin = 1'b1;
                    next_state = T5;
                end else begin
                    last_step = 1'b1;
                end
            end
            T5: begin
                if (is_rtype(opcode) || is_imm(opcode)) begin
                    Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; last_step = 1'b1;
                end else if ((opcode == OP_LD) || (opcode == OP_ST)) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                    next_state = T6;
                end else if ((opcode == OP_MUL) || (opcode == OP_DIV)) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                    next_state = T6;
                end else if (opcode == OP_BR) begin
                    Cout = 1'b1; Zin = 1'b1; operation = ALU_ADD;
                    next_state = T6;
                end else begin
                    last_step = 1'b1;
                end
            end
            T6: begin
                if (opcode == OP_LD) begin
                    Read = 1'b1; MDRin = 1'b1;
                    if (wait_zero) next_state = T7;
                end else if (opcode == OP_ST) begin
                    GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    next_state = T7;
                end else if ((opcode == OP_MUL) || (opcode == OP_DIV)) begin
                    ZHighout = 1'b1; HIin = 1'b1; last_step = 1'b1;
                end else begin
                    // Branch target commit; an untaken branch idles here.
                    if ((opcode == OP_BR) && CON_out) begin
                        Zlowout = 1'b1; PCin = 1'b1;
                    end
                    last_step = 1'b1;
                end
            end
            T7: begin
                if (opcode == OP_LD) begin
                    MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; last_step = 1'b1;
                end else if (opcode == OP_ST) begin
                    Write = 1'b1;
                    if (wait_zero) last_step = 1'b1;
                end else begin
                    last_step = 1'b1;
                end
            end
            HALT: next_state = HALT;
            default: next_state = S_RST;
        endcase

        if (last_step) next_state = stop_pending ? HALT : T0;
    end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Bench for mini_src_control_unit. Two instances (MEM_WAIT=0 and 2) share
// the stimulus; each test picks which one is scored. Every cycle the
// expected control word is queued as the stimulus is applied and popped
// when the registered outputs are sampled after the clock edge.
module tb_mini_src_control_unit;

    localparam int W = 34;

    // Control word layout: [33:29] operation, [28] Run, [27] Illegal,
    // [26:0] single-bit strobes.
    localparam logic [W-1:0] M_PCOUT     = 34'd1 << 0;
    localparam logic [W-1:0] M_PCIN      = 34'd1 << 1;
    localparam logic [W-1:0] M_INCPC     = 34'd1 << 2;
    localparam logic [W-1:0] M_MARIN     = 34'd1 << 3;
    localparam logic [W-1:0] M_MDRIN     = 34'd1 << 4;
    localparam logic [W-1:0] M_MDROUT    = 34'd1 << 5;
    localparam logic [W-1:0] M_READ      = 34'd1 << 6;
    localparam logic [W-1:0] M_WRITE     = 34'd1 << 7;
    localparam logic [W-1:0] M_IRIN      = 34'd1 << 8;
    localparam logic [W-1:0] M_YIN       = 34'd1 << 9;
    localparam logic [W-1:0] M_ZIN       = 34'd1 << 10;
    localparam logic [W-1:0] M_ZLOWOUT   = 34'd1 << 11;
    localparam logic [W-1:0] M_ZHIGHOUT  = 34'd1 << 12;
    localparam logic [W-1:0] M_HIIN      = 34'd1 << 13;
    localparam logic [W-1:0] M_LOIN      = 34'd1 << 14;
    localparam logic [W-1:0] M_HIOUT     = 34'd1 << 15;
    localparam logic [W-1:0] M_LOOUT     = 34'd1 << 16;
    localparam logic [W-1:0] M_COUT      = 34'd1 << 17;
    localparam logic [W-1:0] M_INPORTOUT = 34'd1 << 18;
    localparam logic [W-1:0] M_OUTPORTIN = 34'd1 << 19;
    localparam logic [W-1:0] M_CONIN     = 34'd1 << 20;
    localparam logic [W-1:0] M_BAOUT     = 34'd1 << 21;
    localparam logic [W-1:0] M_GRA       = 34'd1 << 22;
    localparam logic [W-1:0] M_GRB       = 34'd1 << 23;
    localparam logic [W-1:0] M_GRC       = 34'd1 << 24;
    localparam logic [W-1:0] M_RIN       = 34'd1 << 25;
    localparam logic [W-1:0] M_ROUT      = 34'd1 << 26;
    localparam logic [W-1:0] M_ILLEGAL   = 34'd1 << 27;
    localparam logic [W-1:0] M_RUN       = 34'd1 << 28;
    localparam logic [W-1:0] OP_ADDW     = 34'h3 << 29;
    localparam logic [W-1:0] OP_ANDW     = 34'h5 << 29;

    localparam logic [W-1:0] W_T0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_PCIN;
    localparam logic [W-1:0] W_T1 = M_RUN | M_READ | M_MDRIN;
    localparam logic [W-1:0] W_T2 = M_RUN | M_MDROUT | M_IRIN;

    logic        Clock;
    logic        Reset;
    logic [31:0] IR;
    logic        CON_out;
    logic        Stop;
    wire [W-1:0] obs0;
    wire [W-1:0] obs2;
    wire [3:0]   dbg0;
    wire [3:0]   dbg2;

    logic [W-1:0] exp_q[$];
    int           n_vectors;
    int           n_miscompares;
    logic         use_w2;
    string        cur_tag;

    mini_src_control_unit #(.MEM_WAIT(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .IR(IR), .CON_out(CON_out), .Stop(Stop),
        .PCout(obs0[0]), .PCin(obs0[1]), .IncPC(obs0[2]), .MARin(obs0[3]),
        .MDRin(obs0[4]), .MDRout(obs0[5]), .Read(obs0[6]), .Write(obs0[7]),
        .IRin(obs0[8]), .Yin(obs0[9]), .Zin(obs0[10]), .Zlowout(obs0[11]),
        .ZHighout(obs0[12]), .HIin(obs0[13]), .LOin(obs0[14]), .HIout(obs0[15]),
        .LOout(obs0[16]), .Cout(obs0[17]), .InPortout(obs0[18]), .OutPortin(obs0[19]),
        .CONin(obs0[20]), .BAout(obs0[21]), .GRA(obs0[22]), .GRB(obs0[23]),
        .GRC(obs0[24]), .Rin(obs0[25]), .Rout(obs0[26]), .Illegal(obs0[27]),
        .Run(obs0[28]), .operation(obs0[33:29]), .dbg_state(dbg0)
    );

    mini_src_control_unit #(.MEM_WAIT(2)) dut2 (
        .Clock(Clock), .Reset(Reset), .IR(IR), .CON_out(CON_out), .Stop(Stop),
        .PCout(obs2[0]), .PCin(obs2[1]), .IncPC(obs2[2]), .MARin(obs2[3]),
        .MDRin(obs2[4]), .MDRout(obs2[5]), .Read(obs2[6]), .Write(obs2[7]),
        .IRin(obs2[8]), .Yin(obs2[9]), .Zin(obs2[10]), .Zlowout(obs2[11]),
        .ZHighout(obs2[12]), .HIin(obs2[13]), .LOin(obs2[14]), .HIout(obs2[15]),
        .LOout(obs2[16]), .Cout(obs2[17]), .InPortout(obs2[18]), .OutPortin(obs2[19]),
        .CONin(obs2[20]), .BAout(obs2[21]), .GRA(obs2[22]), .GRB(obs2[23]),
        .GRC(obs2[24]), .Rin(obs2[25]), .Rout(obs2[26]), .Illegal(obs2[27]),
        .Run(obs2[28]), .operation(obs2[33:29]), .dbg_state(dbg2)
    );

    // Clock / reset
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Scoreboard check
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, queue the expected word, sample after the edge.
    task automatic step(input logic rst, input logic stp, input logic [W-1:0] exp);
        logic [W-1:0] e;
        Reset = rst;
        Stop  = stp;
        exp_q.push_back(exp);
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        check(cur_tag, use_w2 ? obs2 : obs0, e);
    endtask

    task automatic reset_seq();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
    endtask

    task automatic fetch(input int wait_n);
        step(1'b0, 1'b0, W_T0);
        for (int i = 0; i <= wait_n; i++) step(1'b0, 1'b0, W_T1);
        step(1'b0, 1'b0, W_T2);
    endtask

    task automatic start(input string tag, input logic w2, input logic [31:0] ir, input logic con);
        cur_tag = tag;
        use_w2  = w2;
        IR      = ir;
        CON_out = con;
        reset_seq();
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        Reset   = 1'b1;
        Stop    = 1'b0;
        CON_out = 1'b0;
        IR      = 32'h0;
        use_w2  = 1'b0;
        cur_tag = "init";

        // add R1,R2,R3: 6 cycles then back to T0
        start("add", 1'b0, 32'h18918000, 1'b0);
        fetch(0);
        step(1'b0, 1'b0, M_RUN | M_GRB | M_ROUT | M_YIN);
        step(1'b0, 1'b0, M_RUN | M_GRC | M_ROUT | M_ZIN | OP_ADDW);
        step(1'b0, 1'b0, M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
        step(1'b0, 1'b0, W_T0);

        // andi: logical immediate selects AND
        start("andi", 1'b0, 32'h68800012, 1'b0);
        fetch(0);
        step(1'b0, 1'b0, M_RUN | M_GRB | M_ROUT | M_YIN);
        step(1'b0, 1'b0, M_RUN | M_COUT | M_ZIN | OP_ANDW);
        step(1'b0, 1'b0, M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
        step(1'b0, 1'b0, W_T0);

        // ld R1,0x55(R0) with MEM_WAIT=2: 12 cycles
        start("ld_w2", 1'b1, 32'h00800055, 1'b0);
        fetch(2);
        step(1'b0, 1'b0, M_RUN | M_GRB | M_BAOUT | M_YIN);
        step(1'b0, 1'b0, M_RUN | M_COUT | M_ZIN | OP_ADDW);
        step(1'b0, 1'b0, M_RUN | M_ZLOWOUT | M_MARIN);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, M_RUN | M_READ | M_MDRIN);
        step(1'b0, 1'b0, M_RUN | M_MDROUT | M_GRA | M_RIN);
        step(1'b0, 1'b0, W_T0);

        // st with MEM_WAIT=2: Write held 3 cycles
        start("st_w2", 1'b1, 32'h10800055, 1'b0);
        fetch(2);
        step(1'b0, 1'b0, M_RUN | M_GRB | M_BAOUT | M_YIN);
        step(1'b0, 1'b0, M_RUN | M_COUT | M_ZIN | OP_ADDW);
        step(1'b0, 1'b0, M_RUN | M_ZLOWOUT | M_MARIN);
        step(1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_MDRIN);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, M_RUN | M_WRITE);
        step(1'b0, 1'b0, W_T0);

        // br not taken, then taken
        for (int c = 0; c < 2; c++) begin
            start(c == 0 ? "br_nt" : "br_t", 1'b0, 32'h98000008, c[0]);
            fetch(0);
            step(1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_CONIN);
            step(1'b0, 1'b0, M_RUN | M_PCOUT | M_YIN);
            step(1'b0, 1'b0, M_RUN | M_COUT | M_ZIN | OP_ADDW);
            step(1'b0, 1'b0, (c == 0) ? M_RUN : (M_RUN | M_ZLOWOUT | M_PCIN));
            step(1'b0, 1'b0, W_T0);
        end

        // jr R5
        start("jr", 1'b0, 32'hA2800000, 1'b0);
        fetch(0);
        step(1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_PCIN);
        step(1'b0, 1'b0, W_T0);

        // mfhi
        start("mfhi", 1'b0, 32'hC0800000, 1'b0);
        fetch(0);
        step(1'b0, 1'b0, M_RUN | M_HIOUT | M_GRA | M_RIN);
        step(1'b0, 1'b0, W_T0);

        // halt: Run drops after T3, only Reset leaves HALT
        start("halt", 1'b0, 32'hD8000000, 1'b0);
        fetch(0);
        step(1'b0, 1'b0, M_RUN);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, W_T0);
        step(1'b0, 1'b0, W_T1);

        // Reset during ld T5
        start("ld_rst", 1'b0, 32'h00800055, 1'b0);
        fetch(0);
        step(1'b0, 1'b0, M_RUN | M_GRB | M_BAOUT | M_YIN);
        step(1'b0, 1'b0, M_RUN | M_COUT | M_ZIN | OP_ADDW);
        step(1'b0, 1'b0, M_RUN | M_ZLOWOUT | M_MARIN);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, W_T0);

        // Illegal opcode 11111: one pulse, no strobes
        start("illegal", 1'b0, 32'hF8000000, 1'b0);
        fetch(0);
        step(1'b0, 1'b0, M_RUN | M_ILLEGAL);
        step(1'b0, 1'b0, W_T0);

        // Stop pulsed during T4 of add: HALT after T5
        start("stop", 1'b0, 32'h18918000, 1'b0);
        fetch(0);
        step(1'b0, 1'b0, M_RUN | M_GRB | M_ROUT | M_YIN);
        step(1'b0, 1'b0, M_RUN | M_GRC | M_ROUT | M_ZIN | OP_ADDW);
        step(1'b0, 1'b1, M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
